// File: rtl/bsk_mgr_common_param_pkg.sv
// bsk_mgr_common_param_pkg: shared node command format, RAM geometry and read scheduler states
package bsk_mgr_common_param_pkg;
    localparam int BSK_RAM_ADD_W = 6;
    localparam int BSK_RAM_DEPTH = 48;
    typedef struct packed {
        logic                     ram_rd_enD;
        logic [BSK_RAM_ADD_W-1:0] ram_rd_addD;
        logic                     buf_in_avail;
    } node_cmd_t;
    localparam int NODE_CMD_W = $bits(node_cmd_t);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_sched_state_e;
endpackage

// File: rtl/bsk_mgr_rd_credit.sv
// bsk_mgr_rd_credit: tracks node buffer occupancy plus in-flight reads and grants issue credit
module bsk_mgr_rd_credit #(
    parameter int BUF_DEPTH = 6
) (
    input  logic                 clk,
    input  logic                 s_rst_n,
    input  logic [BUF_DEPTH-1:0] buf_en,
    input  logic                 issue,
    input  logic                 retire,
    output logic                 issue_ok
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    logic [CW-1:0] infl;
    logic [CW:0]   occ;
    always_comb begin
        occ = {1'b0, infl};
        for (int i = 0; i < BUF_DEPTH; i++) occ = occ + {{CW{1'b0}}, buf_en[i]};
    end
    assign issue_ok = occ < (CW+1)'(BUF_DEPTH);
    // retire follows the emitted buf_in_avail, so infl drops exactly when buf_en picks the word up
    always_ff @(posedge clk) begin
        if (!s_rst_n) infl <= '0;
        else if (issue != retire) infl <= issue ? infl + CW'(1) : infl - CW'(1);
    end
`ifndef SYNTHESIS
    a_infl:  assert property (@(posedge clk) disable iff (!s_rst_n) infl <= CW'(BUF_DEPTH));
    a_occ:   assert property (@(posedge clk) disable iff (!s_rst_n) occ <= (CW+1)'(BUF_DEPTH));
    a_avail: assert property (@(posedge clk) disable iff (!s_rst_n) retire |-> infl != '0);
`endif
endmodule

// File: rtl/bsk_mgr_rd_sched.sv
// bsk_mgr_rd_sched: credit-limited read scheduler for one node column, with buf_in_avail
// delayed to match the node's registered rd_en plus RAM read latency
module bsk_mgr_rd_sched
    import bsk_mgr_common_param_pkg::*;
#(
    parameter int RAM_LATENCY = 3,
    parameter int BUF_DEPTH   = RAM_LATENCY + 1 + 2,
    parameter int NB_W        = 16,
    parameter int REP_W       = 8
) (
    input  logic                     clk,
    input  logic                     s_rst_n,
    input  logic                     cmd_vld,
    output logic                     cmd_rdy,
    input  logic [BSK_RAM_ADD_W-1:0] cmd_add,
    input  logic [NB_W-1:0]          cmd_nb,
    input  logic [REP_W-1:0]         cmd_rep,
    output logic [NODE_CMD_W-1:0]    node_cmd,
    input  logic [BUF_DEPTH-1:0]     buf_en,
    output logic                     busy,
    output logic                     done,
    output logic                     err_cmd
);
    rd_sched_state_e          state, state_nxt;
    node_cmd_t                cmd_q;
    logic [BSK_RAM_ADD_W-1:0] add_base, add_cnt, add_inc;
    logic [NB_W-1:0]          nb_last, nb_cnt;
    logic [REP_W-1:0]         rep_last, rep_cnt;
    logic [RAM_LATENCY:0]     pipe;
    logic                     issue_ok, issue, last_nb, last_iss, drain_end, accept, bad;

    bsk_mgr_rd_credit #(.BUF_DEPTH(BUF_DEPTH)) u_credit (
        .clk      (clk),
        .s_rst_n  (s_rst_n),
        .buf_en   (buf_en),
        .issue    (issue),
        .retire   (cmd_q.buf_in_avail),
        .issue_ok (issue_ok)
    );

    assign cmd_rdy   = (state == IDLE) & s_rst_n;
    assign busy      = state != IDLE;
    assign node_cmd  = cmd_q;
    assign accept    = cmd_vld & cmd_rdy;
    assign bad       = (cmd_nb == '0) | (cmd_rep == '0);
    assign issue     = (state == RUN) & issue_ok;
    assign last_nb   = nb_cnt == nb_last;
    assign last_iss  = issue & last_nb & (rep_cnt == rep_last);
    assign add_inc   = (add_cnt == BSK_RAM_ADD_W'(BSK_RAM_DEPTH - 1)) ? '0 : add_cnt + BSK_RAM_ADD_W'(1);
    // no issues in DRAIN, so an empty pipe behind the exiting bit means it is the final read
    assign drain_end = (state == DRAIN) & pipe[RAM_LATENCY] & ~|pipe[RAM_LATENCY-1:0];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (accept && !bad) ? RUN : IDLE;
            RUN:     state_nxt = last_iss ? DRAIN : RUN;
            DRAIN:   state_nxt = drain_end ? IDLE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            state    <= IDLE;
            cmd_q    <= '0;
            pipe     <= '0;
            done     <= 1'b0;
            err_cmd  <= 1'b0;
            add_base <= '0;
            add_cnt  <= '0;
            nb_last  <= '0;
            nb_cnt   <= '0;
            rep_last <= '0;
            rep_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            done    <= drain_end;
            err_cmd <= err_cmd | (accept & bad);
            if (accept) begin
                add_base <= cmd_add;
                add_cnt  <= cmd_add;
                nb_last  <= cmd_nb - NB_W'(1);
                rep_last <= cmd_rep - REP_W'(1);
                nb_cnt   <= '0;
                rep_cnt  <= '0;
            end else if (issue) begin
                nb_cnt  <= last_nb ? '0 : nb_cnt + NB_W'(1);
                add_cnt <= last_nb ? add_base : add_inc;
                rep_cnt <= rep_cnt + REP_W'(last_nb);
            end
            pipe               <= {pipe[RAM_LATENCY-1:0], issue};
            cmd_q.ram_rd_enD   <= issue;
            cmd_q.ram_rd_addD  <= issue ? add_cnt : '0;
            cmd_q.buf_in_avail <= pipe[RAM_LATENCY];
        end
    end
endmodule
